// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count, programmable almost flags,
// sticky overflow/underflow and synchronous flush. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
module sync_fifo_flags #(
   parameter int DWIDTH   = 16,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 2
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [DWIDTH-1:0]        din,
   input  logic                     rd_en,
   output logic [DWIDTH-1:0]        dout,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] AF_L = AF_LEVEL[AW:0];
   localparam logic [AW:0] AE_L = AE_LEVEL[AW:0];

   logic [AW:0]       wptr, rptr;
   logic [DWIDTH-1:0] mem [DEPTH];
   logic              wr_acc, rd_acc;

   // Extra MSB distinguishes full from empty when the index bits match.
   assign empty        = (wptr == rptr);
   assign full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign count        = wptr - rptr;
   assign almost_full  = (count >= AF_L);
   assign almost_empty = (count <= AE_L);

   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr      <= '0;
         rptr      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         wptr      <= '0;
         rptr      <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc)         wptr      <= wptr + 1'b1;
         if (rd_acc)         rptr      <= rptr + 1'b1;
         if (wr_en && full)  overflow  <= 1'b1;
         if (rd_en && empty) underflow <= 1'b1;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_acc && !clr) mem[wptr[AW-1:0]] <= din;
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign dout = mem[rptr[AW-1:0]];
`else
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                dout <= '0;
      else if (rd_acc && !clr)  dout <= mem[rptr[AW-1:0]];
   end
`endif

endmodule
